// File: rtl/seq_pkg.sv
// Shared types and widths for the program sequencer.
package seq_pkg;

    localparam int unsigned WORD_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/prog_buffer.sv
// Program word store: synchronous write port, asynchronous read port.
module prog_buffer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a loaded program to the processor D input one word per EXT strobe.
// Define SEQ_LOOP_EN to repeat the program forever instead of halting.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      CLKb,
    input  logic                      CLR,
    input  logic [WORD_W-1:0]         D_SW,
    input  logic                      LOAD,
    input  logic                      START,
    input  logic                      EXT,
    input  logic                      DONE,
    output logic [WORD_W-1:0]         D_OUT,
    output logic                      RUNNING,
    output logic                      HALTED,
    output logic                      FULL,
    output logic                      EMPTY,
    output logic [$clog2(DEPTH)-1:0]  PC,
    output logic                      ERR
);

    localparam int unsigned PC_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    seq_state_t        state, state_next;
    logic [PC_W-1:0]   pc, pc_next;
    logic [CNT_W-1:0]  count, count_next;
    logic              err, err_next;
    logic              we;
    logic              last;
    logic [WORD_W-1:0] rdata;

    prog_buffer #(.DEPTH(DEPTH), .AW(PC_W)) u_buf (
        .clk   (CLKb),
        .we    (we),
        .waddr (PC_W'(count)),
        .wdata (D_SW),
        .raddr (pc),
        .rdata (rdata)
    );

    assign last = ((CNT_W'(pc) + CNT_W'(1)) == count);

    always_ff @(posedge CLKb) begin
        if (CLR) begin
            state <= IDLE;
            pc    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            count <= count_next;
            err   <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        count_next = count;
        err_next   = err;
        we         = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD && !FULL) begin
                    we         = 1'b1;
                    count_next = count + CNT_W'(1);
                end
                // A same-cycle LOAD makes an empty buffer startable.
                if (START && ((count != '0) || we)) begin
                    pc_next    = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (EXT) begin
                    pc_next = pc + PC_W'(1);
                    if (last) begin
                        if (DONE) begin
`ifdef SEQ_LOOP_EN
                            pc_next    = '0;
                            state_next = RUN;
`else
                            state_next = HALT;
`endif
                        end else begin
                            state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (EXT) begin
                    err_next = 1'b1;
                end
                if (DONE) begin
`ifdef SEQ_LOOP_EN
                    pc_next    = '0;
                    state_next = RUN;
`else
                    state_next = HALT;
`endif
                end
            end
            HALT: begin
                if (START) begin
                    pc_next    = '0;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        D_OUT = '0;
        case (state)
            IDLE:    D_OUT = D_SW;
            RUN:     D_OUT = rdata;
            default: D_OUT = '0;
        endcase
    end

    assign RUNNING = (state == RUN) || (state == DRAIN);
    assign HALTED  = (state == HALT);
    assign FULL    = (count == CNT_W'(DEPTH));
    assign EMPTY   = (count == '0);
    assign PC      = pc;
    assign ERR     = err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (DEPTH = 8).
module tb_instr_sequencer;

    localparam int unsigned DEPTH = 8;

    logic       CLKb = 1'b0;
    logic       CLR, LOAD, START, EXT, DONE;
    logic [9:0] D_SW;
    logic [9:0] D_OUT;
    logic       RUNNING, HALTED, FULL, EMPTY, ERR;
    logic [2:0] PC;

    int checks   = 0;
    int failures = 0;

    logic [9:0] vals [9];

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .CLKb    (CLKb),
        .CLR     (CLR),
        .D_SW    (D_SW),
        .LOAD    (LOAD),
        .START   (START),
        .EXT     (EXT),
        .DONE    (DONE),
        .D_OUT   (D_OUT),
        .RUNNING (RUNNING),
        .HALTED  (HALTED),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .PC      (PC),
        .ERR     (ERR)
    );

    always #5 CLKb = ~CLKb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    task automatic load_word(input logic [9:0] w);
        D_SW = w;
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
    endtask

    task automatic pulse_ext(input logic with_done);
        EXT  = 1'b1;
        DONE = with_done;
        tick();
        EXT  = 1'b0;
        DONE = 1'b0;
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b0; LOAD = 1'b0; START = 1'b0; EXT = 1'b0; DONE = 1'b0;
        D_SW = 10'h155;
        #1;
        do_clr();

        check("rst_dout",    32'(D_OUT),   32'h155);
        check("rst_running", 32'(RUNNING), 32'd0);
        check("rst_halted",  32'(HALTED),  32'd0);
        check("rst_full",    32'(FULL),    32'd0);
        check("rst_empty",   32'(EMPTY),   32'd1);
        check("rst_pc",      32'(PC),      32'd0);
        check("rst_err",     32'(ERR),     32'd0);

        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_empty_ignored", 32'(RUNNING), 32'd0);

        load_word(10'h101);
        load_word(10'h2A5);
        load_word(10'h0F0);
        D_SW = 10'h155;
        #1;
        check("load_empty", 32'(EMPTY), 32'd0);
        check("load_full",  32'(FULL),  32'd0);
        check("idle_pass",  32'(D_OUT), 32'h155);

        START = 1'b1;
        tick();
        START = 1'b0;
        check("run_running", 32'(RUNNING), 32'd1);
        check("run_pc0",     32'(PC),      32'd0);
        check("run_w0",      32'(D_OUT),   32'h101);
        tick();
        check("run_hold_w0", 32'(D_OUT),   32'h101);
        pulse_ext(1'b0);
        check("run_pc1",     32'(PC),      32'd1);
        check("run_w1",      32'(D_OUT),   32'h2A5);
        tick();
        pulse_ext(1'b0);
        check("run_pc2",     32'(PC),      32'd2);
        check("run_w2",      32'(D_OUT),   32'h0F0);
        pulse_ext(1'b1);
`ifdef SEQ_LOOP_EN
        check("loop_running", 32'(RUNNING), 32'd1);
        check("loop_halted",  32'(HALTED),  32'd0);
        check("loop_pc",      32'(PC),      32'd0);
        check("loop_dout",    32'(D_OUT),   32'h101);
`else
        check("halt_halted",  32'(HALTED),  32'd1);
        check("halt_running", 32'(RUNNING), 32'd0);
        check("halt_dout",    32'(D_OUT),   32'h000);
        load_word(10'h3C3);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("rerun_pc",   32'(PC),      32'd0);
        check("rerun_dout", 32'(D_OUT),   32'h101);
`endif

        // Run to the end without DONE, then over-request in DRAIN.
        pulse_ext(1'b0);
        pulse_ext(1'b0);
        pulse_ext(1'b0);
        check("drain_running", 32'(RUNNING), 32'd1);
        check("drain_dout",    32'(D_OUT),   32'h000);
        check("drain_err0",    32'(ERR),     32'd0);
        pulse_ext(1'b0);
        check("drain_err1",    32'(ERR),     32'd1);
        check("drain_stay",    32'(RUNNING), 32'd1);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
`ifdef SEQ_LOOP_EN
        check("drain_loop_pc",  32'(PC),     32'd0);
        check("drain_loop_hlt", 32'(HALTED), 32'd0);
`else
        check("drain_halt",     32'(HALTED), 32'd1);
`endif
        check("err_sticky", 32'(ERR), 32'd1);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("restart_pc",   32'(PC),      32'd0);
        check("restart_dout", 32'(D_OUT),   32'h101);
        check("restart_err",  32'(ERR),     32'd1);
        pulse_ext(1'b0);
        check("pre_clr_pc",   32'(PC),      32'd1);

        D_SW = 10'h0AA;
        do_clr();
        check("clr_running", 32'(RUNNING), 32'd0);
        check("clr_empty",   32'(EMPTY),   32'd1);
        check("clr_err",     32'(ERR),     32'd0);
        check("clr_pc",      32'(PC),      32'd0);
        check("clr_dout",    32'(D_OUT),   32'h0AA);

        // LOAD and START together on an empty buffer.
        D_SW  = 10'h3FF;
        LOAD  = 1'b1;
        START = 1'b1;
        tick();
        LOAD  = 1'b0;
        START = 1'b0;
        check("ldst_running", 32'(RUNNING), 32'd1);
        check("ldst_dout",    32'(D_OUT),   32'h3FF);
        check("ldst_empty",   32'(EMPTY),   32'd0);
        do_clr();

        for (int i = 0; i < 9; i++) vals[i] = 10'(i * 37 + 5);
        vals[8] = 10'h3AA;
        for (int i = 0; i < 9; i++) begin
            load_word(vals[i]);
            if (i == 6) check("full_at7", 32'(FULL), 32'd0);
            if (i == 7) check("full_at8", 32'(FULL), 32'd1);
        end
        check("full_after9", 32'(FULL), 32'd1);

        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("deep_pc%0d", k), 32'(PC),    32'(k));
            check($sformatf("deep_w%0d", k),  32'(D_OUT), 32'(vals[k]));
            pulse_ext(1'b0);
        end
        check("deep_drain_run",  32'(RUNNING), 32'd1);
        check("deep_drain_dout", 32'(D_OUT),   32'h000);
        check("deep_drain_err",  32'(ERR),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
